// File: rtl/watchdog_supervisor_pkg.sv
// Shared SPI-side definitions for the watchdog supervisor: FSM state type and
// default widths for the watchdog cycle count and the timeout error counter.
package watchdog_supervisor_pkg;

  localparam int WDT_N     = 4;
  localparam int WDT_ERR_M = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    WAIT   = 3'd2,
    DISARM = 3'd3,
    FAULT  = 3'd4
  } wdt_sup_state_t;

endpackage

// File: rtl/watchdog_supervisor_sat_counter.sv
// Saturating event counter. A clear in the same cycle as an increment leaves
// the count at 1: the clear applies first, then the increment.
module sat_counter #(
  parameter int M = 8
) (
  input  logic         i_clk_p,
  input  logic         i_rst_p,
  input  logic         inc,
  input  logic         clr,
  output logic [M-1:0] count
);

  localparam logic [M-1:0] MAX_COUNT = '1;

  // Count up on inc, stick at all-ones, clear-then-increment on clr.
  always_ff @(posedge i_clk_p) begin
    if (i_rst_p) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? M'(1) : '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + M'(1);
    end
  end

endmodule

// File: rtl/watchdog_supervisor.sv
// Control-side supervisor for the SPI watchdog. Arms the watchdog when a
// transaction starts, re-arms it on kick, disarms it on completion, and turns
// a watchdog interrupt into an abort pulse, a sticky host interrupt and a
// saturating timeout count.
//
// Handshake: i_start, i_done, i_ack and i_clr are single-cycle pulses sampled
// on the rising edge; o_we is a one-cycle load strobe with o_cycles valid in
// the same cycle; o_abort is a one-cycle pulse the SPI engine must act on.
// There is no back-pressure on any of these signals.
module watchdog_supervisor
  import watchdog_supervisor_pkg::*;
#(
  parameter int N = WDT_N,
  parameter int M = WDT_ERR_M
) (
  input  logic           i_clk_p,
  input  logic           i_rst_p,
  input  logic [N-1:0]   i_timeout,
  input  logic           i_start,
  input  logic           i_done,
  input  logic           i_inter,
  input  logic           i_ack,
  input  logic           i_clr,
  output logic [N-1:0]   o_cycles,
  output logic           o_we,
  output logic           o_abort,
  output logic           o_timeout_irq,
  output logic [M-1:0]   o_err_cnt,
  output logic           o_busy,
  output wdt_sup_state_t o_state
);

  wdt_sup_state_t state;
  wdt_sup_state_t state_nxt;
  logic [N-1:0]   s_timeout;
  logic [N-1:0]   s_timeout_nxt;
  logic           fault_entry;

  // Next-state decode; in WAIT completion beats kick, and kick beats timeout.
  always_comb begin
    state_nxt     = state;
    s_timeout_nxt = s_timeout;
    case (state)
      IDLE: begin
        if (i_start && (i_timeout != '0)) begin
          state_nxt     = ARM;
          s_timeout_nxt = i_timeout;
        end
      end
      ARM: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (i_done) begin
          state_nxt = DISARM;
        end else if (i_start) begin
          s_timeout_nxt = i_timeout;
          state_nxt     = (i_timeout != '0) ? ARM : DISARM;
        end else if (i_inter) begin
          state_nxt = FAULT;
        end
      end
      DISARM: begin
        state_nxt = IDLE;
      end
      FAULT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FAULT is always left after one cycle, so every transition into it is a
  // fresh timeout event.
  assign fault_entry = (state_nxt == FAULT) && (state != FAULT);

  // State register with Moore outputs registered from the next state, so each
  // output lines up with the state it belongs to.
  always_ff @(posedge i_clk_p) begin
    if (i_rst_p) begin
      state     <= IDLE;
      s_timeout <= '0;
      o_we      <= 1'b0;
      o_cycles  <= '0;
      o_abort   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_timeout <= s_timeout_nxt;
      o_we      <= (state_nxt == ARM) || (state_nxt == DISARM) || (state_nxt == FAULT);
      o_cycles  <= (state_nxt == ARM) ? s_timeout_nxt : '0;
      o_abort   <= (state_nxt == FAULT);
      o_busy    <= (state_nxt != IDLE);
    end
  end

  // Sticky host interrupt; a new timeout wins over a simultaneous acknowledge.
  always_ff @(posedge i_clk_p) begin
    if (i_rst_p) begin
      o_timeout_irq <= 1'b0;
    end else if (fault_entry) begin
      o_timeout_irq <= 1'b1;
    end else if (i_ack) begin
      o_timeout_irq <= 1'b0;
    end
  end

  sat_counter #(
    .M (M)
  ) u_err_cnt (
    .i_clk_p (i_clk_p),
    .i_rst_p (i_rst_p),
    .inc     (fault_entry),
    .clr     (i_clr),
    .count   (o_err_cnt)
  );

  assign o_state = state;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Bench for watchdog_supervisor: a behavioural down-counting watchdog closes
// the loop, a write monitor checks every watchdog load against an expected
// queue, and one task per scenario checks the rest inline.
module tb_watchdog_supervisor;
  import watchdog_supervisor_pkg::*;

  localparam int N = 4;
  localparam int M = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   timeout;
  logic           start, done, ack, clr;
  logic           inter;

  logic [N-1:0]   o_cycles, o_cycles2;
  logic           o_we, o_we2, o_abort, o_abort2, o_irq, o_irq2, o_busy, o_busy2;
  logic [M-1:0]   o_err;
  logic [1:0]     o_err2;
  wdt_sup_state_t o_state, o_state2;

  int vectors = 0;
  int errors  = 0;
  int exp_err = 0;
  int exp_err2 = 0;

  logic [N:0] exp_q[$];
  logic [N:0] exp_w;

  watchdog_supervisor #(.N(N), .M(M)) dut (
    .i_clk_p (clk), .i_rst_p (rst), .i_timeout (timeout), .i_start (start),
    .i_done (done), .i_inter (inter), .i_ack (ack), .i_clr (clr),
    .o_cycles (o_cycles), .o_we (o_we), .o_abort (o_abort),
    .o_timeout_irq (o_irq), .o_err_cnt (o_err), .o_busy (o_busy), .o_state (o_state)
  );

  // Narrow-counter copy driven identically, used for the saturation boundary.
  watchdog_supervisor #(.N(N), .M(2)) dut_m2 (
    .i_clk_p (clk), .i_rst_p (rst), .i_timeout (timeout), .i_start (start),
    .i_done (done), .i_inter (inter), .i_ack (ack), .i_clr (clr),
    .o_cycles (o_cycles2), .o_we (o_we2), .o_abort (o_abort2),
    .o_timeout_irq (o_irq2), .o_err_cnt (o_err2), .o_busy (o_busy2), .o_state (o_state2)
  );

  // ---------------- watchdog model ----------------
  // Load C>0: interrupt C cycles after the load edge, then every C+1 cycles.
  logic [N:0]   wd_cnt;
  logic [N-1:0] wd_c;
  logic         wd_act;

  always @(posedge clk) begin
    if (rst) begin
      wd_act <= 1'b0;
      wd_cnt <= '0;
      wd_c   <= '0;
    end else if (o_we) begin
      wd_c   <= o_cycles;
      wd_cnt <= {1'b0, o_cycles};
      wd_act <= (o_cycles != '0);
    end else if (wd_act) begin
      wd_cnt <= (wd_cnt == 1) ? ({1'b0, wd_c} + 1'b1) : (wd_cnt - 1'b1);
    end
  end

  assign inter = wd_act && (wd_cnt == 1);

  // ---------------- scoreboard: watchdog writes ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (o_we) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wd_write_unexpected got abort=%0b cycles=%0d want none", o_abort, o_cycles);
        end else begin
          exp_w = exp_q.pop_front();
          if ({o_abort, o_cycles} !== exp_w) begin
            errors++;
            $display("FAIL wd_write got abort=%0b cycles=%0d want abort=%0b cycles=%0d",
                     o_abort, o_cycles, exp_w[N], exp_w[N-1:0]);
          end
        end
      end else if (o_abort) begin
        vectors++;
        errors++;
        $display("FAIL abort_without_write got abort=1 want 0");
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fault_count(input bit with_clr);
    if (with_clr) begin
      exp_err  = 1;
      exp_err2 = 1;
    end else begin
      exp_err  = (exp_err  == 255) ? 255 : exp_err + 1;
      exp_err2 = (exp_err2 == 3)   ? 3   : exp_err2 + 1;
    end
  endtask

  // Steps until the watchdog interrupt is high; n = cycles waited.
  task automatic wait_inter(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      if (inter) begin
        n = i;
        break;
      end
      step();
    end
    if (n < 0) begin
      vectors++;
      errors++;
      $display("FAIL wait_inter got no interrupt within 40 cycles want interrupt");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; timeout = '0; start = 0; done = 0; ack = 0; clr = 0;
    step(); step();
    rst = 1'b0;
    vectors++; if (o_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", o_we); end
    vectors++; if (o_cycles !== '0) begin errors++; $display("FAIL reset_cycles got %0d want 0", o_cycles); end
    vectors++; if (o_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %0b want 0", o_abort); end
    vectors++; if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", o_irq); end
    vectors++; if (o_err !== '0) begin errors++; $display("FAIL reset_err got %0d want 0", o_err); end
    vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    vectors++; if (o_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", o_state, IDLE); end
  endtask

  task automatic test_normal();
    timeout = 4'd5; start = 1; exp_q.push_back({1'b0, 4'd5});
    step(); start = 0;
    vectors++; if ({o_we, o_cycles} !== {1'b1, 4'd5}) begin errors++; $display("FAIL normal_arm got we=%0b cycles=%0d want we=1 cycles=5", o_we, o_cycles); end
    vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL normal_busy got %0b want 1", o_busy); end
    step(); step();
    done = 1; exp_q.push_back({1'b0, 4'd0});
    step(); done = 0;
    vectors++; if (o_state !== DISARM) begin errors++; $display("FAIL normal_disarm got %0d want %0d", o_state, DISARM); end
    step();
    vectors++; if ({o_busy, o_we} !== 2'b00) begin errors++; $display("FAIL normal_idle got busy=%0b we=%0b want 0 0", o_busy, o_we); end
    vectors++; if (o_err !== M'(exp_err)) begin errors++; $display("FAIL normal_err got %0d want %0d", o_err, exp_err); end
  endtask

  task automatic test_timeout();
    int n;
    timeout = 4'd3; start = 1; exp_q.push_back({1'b0, 4'd3});
    step(); start = 0;
    wait_inter(n);
    vectors++; if (n != 3) begin errors++; $display("FAIL timeout_latency got %0d want 3", n); end
    exp_q.push_back({1'b1, 4'd0}); exp_fault_count(1'b0);
    step();
    vectors++; if ({o_abort, o_irq} !== 2'b11) begin errors++; $display("FAIL timeout_fault got abort=%0b irq=%0b want 1 1", o_abort, o_irq); end
    vectors++; if (o_err !== M'(exp_err)) begin errors++; $display("FAIL timeout_err got %0d want %0d", o_err, exp_err); end
    step(); step();
    vectors++; if ({o_irq, o_busy} !== 2'b10) begin errors++; $display("FAIL timeout_sticky got irq=%0b busy=%0b want 1 0", o_irq, o_busy); end
    ack = 1; step(); ack = 0;
    vectors++; if (o_irq !== 1'b0) begin errors++; $display("FAIL timeout_ack got %0b want 0", o_irq); end
  endtask

  task automatic test_race();
    int n;
    timeout = 4'd2; start = 1; exp_q.push_back({1'b0, 4'd2});
    step(); start = 0;
    wait_inter(n);
    vectors++; if (n != 2) begin errors++; $display("FAIL race_latency got %0d want 2", n); end
    done = 1; exp_q.push_back({1'b0, 4'd0});
    step(); done = 0;
    vectors++; if ({o_state, o_abort} !== {DISARM, 1'b0}) begin errors++; $display("FAIL race_disarm got state=%0d abort=%0b want %0d 0", o_state, o_abort, DISARM); end
    step();
    vectors++; if (o_err !== M'(exp_err)) begin errors++; $display("FAIL race_err got %0d want %0d", o_err, exp_err); end
    vectors++; if (o_irq !== 1'b0) begin errors++; $display("FAIL race_irq got %0b want 0", o_irq); end
  endtask

  task automatic test_kick();
    int arms = 0;
    bit saw = 0;
    timeout = 4'd4; start = 1; exp_q.push_back({1'b0, 4'd4});
    step(); start = 0;
    for (int k = 0; k < 3; k++) begin
      if (o_we && o_cycles == 4'd4 && o_state == ARM) arms++;
      step(); saw |= inter;
      if (k < 2) begin
        step(); saw |= inter;
        start = 1; exp_q.push_back({1'b0, 4'd4});
        step(); start = 0;
      end
    end
    done = 1; exp_q.push_back({1'b0, 4'd0});
    step(); done = 0;
    step();
    vectors++; if (arms != 3) begin errors++; $display("FAIL kick_arms got %0d want 3", arms); end
    vectors++; if (saw !== 1'b0) begin errors++; $display("FAIL kick_inter got %0b want 0", saw); end
    vectors++; if (o_err !== M'(exp_err)) begin errors++; $display("FAIL kick_err got %0d want %0d", o_err, exp_err); end
  endtask

  task automatic test_zero_timeout();
    timeout = 4'd0; start = 1;
    step(); start = 0;
    vectors++; if ({o_we, o_busy} !== 2'b00) begin errors++; $display("FAIL zero_start got we=%0b busy=%0b want 0 0", o_we, o_busy); end
    step();
    vectors++; if (o_state !== IDLE) begin errors++; $display("FAIL zero_state got %0d want %0d", o_state, IDLE); end
  endtask

  task automatic test_kick_zero();
    timeout = 4'd5; start = 1; exp_q.push_back({1'b0, 4'd5});
    step(); start = 0;
    step();
    timeout = 4'd0; start = 1; exp_q.push_back({1'b0, 4'd0});
    step(); start = 0;
    vectors++; if (o_state !== DISARM) begin errors++; $display("FAIL kick_zero_state got %0d want %0d", o_state, DISARM); end
    step();
    vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL kick_zero_busy got %0b want 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    timeout = 4'd3; start = 1; exp_q.push_back({1'b0, 4'd3});
    step(); start = 0;
    step();
    done = 1; exp_q.push_back({1'b0, 4'd0});
    step(); done = 0;
    step();
    vectors++; if (o_state !== IDLE) begin errors++; $display("FAIL b2b_idle got %0d want %0d", o_state, IDLE); end
    timeout = 4'd2; start = 1; exp_q.push_back({1'b0, 4'd2});
    step(); start = 0;
    vectors++; if ({o_state, o_cycles} !== {ARM, 4'd2}) begin errors++; $display("FAIL b2b_arm got state=%0d cycles=%0d want %0d 2", o_state, o_cycles, ARM); end
    step();
    done = 1; exp_q.push_back({1'b0, 4'd0});
    step(); done = 0;
    step();
  endtask

  // One full timeout with C=1, optionally with ack or clr on the fault edge.
  task automatic do_timeout(input bit ack_c, input bit clr_c);
    int n;
    timeout = 4'd1; start = 1; exp_q.push_back({1'b0, 4'd1});
    step(); start = 0;
    wait_inter(n);
    ack = ack_c; clr = clr_c;
    exp_q.push_back({1'b1, 4'd0}); exp_fault_count(clr_c);
    step(); ack = 0; clr = 0;
    vectors++; if ({o_abort, o_irq} !== 2'b11) begin errors++; $display("FAIL fault_flags got abort=%0b irq=%0b want 1 1", o_abort, o_irq); end
    vectors++; if (o_err !== M'(exp_err)) begin errors++; $display("FAIL fault_err got %0d want %0d", o_err, exp_err); end
    vectors++; if (o_err2 !== 2'(exp_err2)) begin errors++; $display("FAIL fault_err_m2 got %0d want %0d", o_err2, exp_err2); end
    step();
  endtask

  task automatic test_saturation();
    clr = 1; step(); clr = 0;
    exp_err = 0; exp_err2 = 0;
    vectors++; if ({o_err2, o_err} !== '0) begin errors++; $display("FAIL clr_err got %0d/%0d want 0/0", o_err, o_err2); end
    for (int i = 0; i < 4; i++) do_timeout(1'b0, 1'b0);
    vectors++; if (o_err2 !== 2'd3) begin errors++; $display("FAIL sat_m2 got %0d want 3", o_err2); end
  endtask

  task automatic test_clr_coincide();
    do_timeout(1'b0, 1'b1);
  endtask

  task automatic test_ack_coincide();
    ack = 1; step(); ack = 0;
    vectors++; if (o_irq !== 1'b0) begin errors++; $display("FAIL ack_clear got %0b want 0", o_irq); end
    do_timeout(1'b1, 1'b0);
    vectors++; if (o_irq !== 1'b1) begin errors++; $display("FAIL ack_coincide_hold got %0b want 1", o_irq); end
  endtask

  task automatic test_reset_mid();
    timeout = 4'd6; start = 1; exp_q.push_back({1'b0, 4'd6});
    step(); start = 0;
    step(); step();
    rst = 1;
    step();
    vectors++; if ({o_we, o_abort, o_busy, o_irq} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got we=%0b abort=%0b busy=%0b irq=%0b want 0000", o_we, o_abort, o_busy, o_irq); end
    vectors++; if ({o_err, o_cycles} !== '0) begin errors++; $display("FAIL rstmid_vals got err=%0d cycles=%0d want 0 0", o_err, o_cycles); end
    vectors++; if (o_state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want %0d", o_state, IDLE); end
    rst = 0; exp_err = 0; exp_err2 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++; if ({o_abort, o_busy, inter} !== 3'b000) begin errors++; $display("FAIL rstmid_quiet got abort=%0b busy=%0b inter=%0b want 000", o_abort, o_busy, inter); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_race();
    test_kick();
    test_zero_timeout();
    test_kick_zero();
    test_back_to_back();
    test_saturation();
    test_clr_coincide();
    test_ack_coincide();
    test_reset_mid();
    step();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending writes want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
